// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the main-memory arbiter: FSM/owner encodings
// and line geometry (beat index width, line offset mask).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_LIM_DEF = 4;

  function automatic int unsigned beat_w(input int unsigned line_words);
    return (line_words < 2) ? 1 : $clog2(line_words);
  endfunction

  // Byte-offset bits of a line: word index plus the 2-bit byte offset.
  function automatic int unsigned line_off_w(input int unsigned line_words);
    return beat_w(line_words) + 2;
  endfunction

  function automatic logic [63:0] line_off_mask(input int unsigned line_words);
    return (64'd1 << line_off_w(line_words)) - 64'd1;
  endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// IDLE grant decision (dcache priority) with a starvation counter that
// forces an icache grant after STARVE_LIM dcache wins over a waiting icache.
module arb_prio_starve
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle_i,
  input  logic ic_req_i,
  input  logic dc_req_i,
  output logic grant_ic_c_o,
  output logic grant_dc_c_o
);

  localparam int unsigned CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dc_win, ic_win;

  always_comb begin
    dc_win = idle_i && dc_req_i && (!ic_req_i || (cnt_q < LIM));
    ic_win = idle_i && ic_req_i && !dc_win;
    cnt_d  = cnt_q;
    if (idle_i) begin
      if (dc_win && ic_req_i) begin
        cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + CNT_W'(1);
      end else if (ic_win || !ic_req_i) begin
        cnt_d = '0;
      end
    end
  end

  assign grant_dc_c_o = dc_win;
  assign grant_ic_c_o = ic_win;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between icache refills and dcache
// refills/write-backs, issuing each miss as a LINE_WORDS-beat burst.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF,
  localparam int unsigned BEAT_W    = beat_w(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_rvalid_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_rvalid_o,
  output logic              dc_done_o,
  output logic [DATA_W-1:0] arb_rdata_o,
  output logic [BEAT_W-1:0] arb_beat_o,
  output logic [BEAT_W-1:0] arb_beat_cur_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              busy_o,
  output logic              owner_o
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(line_off_mask(LINE_WORDS));
  localparam logic [BEAT_W-1:0] LAST     = BEAT_W'(LINE_WORDS - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [BEAT_W-1:0] rbeat_q, rbeat_d;
  logic              ic_rv_q, ic_rv_d;
  logic              dc_rv_q, dc_rv_d;
  logic              ic_done_q, ic_done_d;
  logic              dc_done_q, dc_done_d;
  logic              mem_req_q, mem_req_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              grant_ic, grant_dc;

  arb_prio_starve #(
    .STARVE_LIM(STARVE_LIM)
  ) u_prio (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .idle_i      (state_q == ST_IDLE),
    .ic_req_i    (ic_req_i),
    .dc_req_i    (dc_req_i),
    .grant_ic_c_o(grant_ic),
    .grant_dc_c_o(grant_dc)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    base_d  = base_q;
    beat_d  = beat_q;
    rdata_d = rdata_q;
    rbeat_d = rbeat_q;
    ic_rv_d = 1'b0;
    dc_rv_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_dc) begin
          owner_d = OWN_DC;
          we_d    = dc_we_i;
          base_d  = dc_addr_i & ~OFF_MASK;
          beat_d  = '0;
          state_d = ST_BURST;
        end else if (grant_ic) begin
          owner_d = OWN_IC;
          we_d    = 1'b0;
          base_d  = ic_addr_i & ~OFF_MASK;
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (mem_ready_i) begin
          beat_d = beat_q + BEAT_W'(1);
          if (!we_q) begin
            rdata_d = mem_rdata_i;
            rbeat_d = beat_q;
            ic_rv_d = (owner_q == OWN_IC);
            dc_rv_d = (owner_q == OWN_DC);
          end
          if (beat_q == LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_req_d = (state_d == ST_BURST);
    busy_d    = (state_d != ST_IDLE);
    ic_done_d = (state_d == ST_DONE) && (owner_d == OWN_IC);
    dc_done_d = (state_d == ST_DONE) && (owner_d == OWN_DC);
    addr_d    = base_d + ADDR_W'({beat_d, 2'b00});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IC;
      we_q      <= 1'b0;
      base_q    <= '0;
      beat_q    <= '0;
      rdata_q   <= '0;
      rbeat_q   <= '0;
      ic_rv_q   <= 1'b0;
      dc_rv_q   <= 1'b0;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      base_q    <= base_d;
      beat_q    <= beat_d;
      rdata_q   <= rdata_d;
      rbeat_q   <= rbeat_d;
      ic_rv_q   <= ic_rv_d;
      dc_rv_q   <= dc_rv_d;
      ic_done_q <= ic_done_d;
      dc_done_q <= dc_done_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
    end
  end

  assign ic_rvalid_o    = ic_rv_q;
  assign dc_rvalid_o    = dc_rv_q;
  assign ic_done_o      = ic_done_q;
  assign dc_done_o      = dc_done_q;
  assign arb_rdata_o    = rdata_q;
  assign arb_beat_o     = rbeat_q;
  assign arb_beat_cur_o = beat_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  // Write data is steered straight from the dcache, which indexes by beat.
  assign mem_wdata_o    = dc_wdata_i;
  assign busy_o         = busy_q;
  assign owner_o        = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: read words expected per accepted beat are
// queued and matched against rvalid output; burst shape checked beat by beat.
module tb_mem_arbiter;

  localparam logic IC = 1'b0;
  localparam logic DC = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req, dc_req, dc_we, mem_ready;
  logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic        ic_rvalid, ic_done, dc_rvalid, dc_done;
  logic [31:0] arb_rdata, mem_addr, mem_wdata;
  logic [1:0]  arb_beat, arb_beat_cur;
  logic        mem_req, mem_we, busy, owner;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        own;
    logic [1:0]  beat;
    logic [31:0] data;
  } rd_t;
  rd_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ic_req_i      (ic_req),
    .ic_addr_i     (ic_addr),
    .ic_rvalid_o   (ic_rvalid),
    .ic_done_o     (ic_done),
    .dc_req_i      (dc_req),
    .dc_we_i       (dc_we),
    .dc_addr_i     (dc_addr),
    .dc_wdata_i    (dc_wdata),
    .dc_rvalid_o   (dc_rvalid),
    .dc_done_o     (dc_done),
    .arb_rdata_o   (arb_rdata),
    .arb_beat_o    (arb_beat),
    .arb_beat_cur_o(arb_beat_cur),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_ready_i   (mem_ready),
    .busy_o        (busy),
    .owner_o       (owner)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory and dcache write-data models.
  assign mem_rdata = mdata(mem_addr);
  assign dc_wdata  = 32'hD00D_0000 | 32'(arb_beat_cur);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read-return monitor: every rvalid must match the oldest queued beat.
  always @(negedge clk) begin : rd_mon
    rd_t e;
    if (rst_n && (ic_rvalid || dc_rvalid)) begin
      check("rv_exclusive", 64'(ic_rvalid && dc_rvalid), 0);
      if (exp_q.size() == 0) begin
        check("rv_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rv_owner", 64'(dc_rvalid), 64'(e.own));
        check("rv_beat", 64'(arb_beat), 64'(e.beat));
        check("rv_data", 64'(arb_rdata), 64'(e.data));
      end
    end
  end

  // Runs one granted burst from the negedge after the request was raised;
  // returns at the negedge of the DONE cycle.
  task automatic do_burst(input string tag, input logic own, input logic [31:0] addr,
                          input logic we, input logic [15:0] pat, input int npat,
                          input int drop_beat, output int lat, output int ncyc);
    logic [31:0] base;
    int          beat;
    int          i;
    logic        rdy;
    rd_t         e;
    base      = addr & ~32'hF;
    lat       = 0;
    ncyc      = 0;
    mem_ready = 1'b0;
    for (int w = 1; w <= 20; w++) begin
      @(negedge clk);
      if (mem_req) begin
        lat = w;
        break;
      end
    end
    if (lat == 0) begin
      check({tag, "_grant_timeout"}, 0, 1);
      return;
    end
    check({tag, "_owner"}, 64'(owner), 64'(own));
    check({tag, "_busy"}, 64'(busy), 1);
    beat = 0;
    i    = 0;
    while (beat < 4 && i < 64) begin
      check({tag, "_req"}, 64'(mem_req), 1);
      check({tag, "_addr"}, 64'(mem_addr), 64'(base + 32'(4 * beat)));
      check({tag, "_we"}, 64'(mem_we), 64'(we));
      check({tag, "_beat_cur"}, 64'(arb_beat_cur), 64'(beat));
      if (we) check({tag, "_wdata"}, 64'(mem_wdata), 64'(32'hD00D_0000 | 32'(beat)));
      rdy       = (i < npat) ? pat[i] : 1'b1;
      mem_ready = rdy;
      if (rdy && !we) begin
        e.own  = own;
        e.beat = 2'(beat);
        e.data = mdata(base + 32'(4 * beat));
        exp_q.push_back(e);
      end
      @(negedge clk);
      i++;
      if (rdy) begin
        if (beat == drop_beat) begin
          // Requester gives up and scribbles address/we: burst must ignore it.
          if (own) begin
            dc_req  = 1'b0;
            dc_addr = ~dc_addr;
            dc_we   = ~dc_we;
          end else begin
            ic_req  = 1'b0;
            ic_addr = ~ic_addr;
          end
        end
        beat++;
      end
    end
    ncyc      = i;
    mem_ready = 1'b0;
    if (beat < 4) check({tag, "_burst_timeout"}, 0, 1);
    check({tag, "_done_req"}, 64'(mem_req), 0);
    check({tag, "_ic_done"}, 64'(ic_done), 64'(!own));
    check({tag, "_dc_done"}, 64'(dc_done), 64'(own));
    check({tag, "_done_busy"}, 64'(busy), 1);
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_idle_busy"}, 64'(busy), 0);
    check({tag, "_idle_req"}, 64'(mem_req), 0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, ncyc;
    rst_n     = 1'b0;
    ic_req    = 1'b0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    ic_addr   = '0;
    dc_addr   = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_rvalid", 64'({ic_rvalid, dc_rvalid}), 0);
    check("rst_done", 64'({ic_done, dc_done}), 0);
    check("rst_beat_cur", 64'(arb_beat_cur), 0);
    check("rst_addr", 64'(mem_addr), 0);
    check("rst_owner_we", 64'({owner, mem_we}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: icache refill, always ready.
    ic_addr = 32'h0000_1234;
    ic_req  = 1'b1;
    do_burst("t1", IC, 32'h0000_1234, 1'b0, 16'h0, 0, -1, lat, ncyc);
    ic_req = 1'b0;
    check("t1_latency", 64'(lat), 1);
    check("t1_cycles", 64'(ncyc), 4);
    settle("t1");

    // 2: simultaneous requests, dcache first then icache.
    dc_we   = 1'b0;
    dc_addr = 32'h0000_2000;
    ic_addr = 32'h0000_5678;
    dc_req  = 1'b1;
    ic_req  = 1'b1;
    do_burst("t2dc", DC, 32'h0000_2000, 1'b0, 16'h0, 0, -1, lat, ncyc);
    dc_req = 1'b0;
    check("t2_dc_latency", 64'(lat), 1);
    check("t2_starve_1", 64'(dut.u_prio.cnt_q), 1);
    do_burst("t2ic", IC, 32'h0000_5678, 1'b0, 16'h0, 0, -1, lat, ncyc);
    ic_req = 1'b0;
    check("t2_ic_latency", 64'(lat), 2);
    check("t2_starve_0", 64'(dut.u_prio.cnt_q), 0);
    settle("t2");

    // 3: dcache write-back with stalls 1,0,0,1,1,0,1.
    dc_we   = 1'b1;
    dc_addr = 32'h8000_0044;
    dc_req  = 1'b1;
    do_burst("t3", DC, 32'h8000_0044, 1'b1, 16'h0059, 7, -1, lat, ncyc);
    dc_req = 1'b0;
    check("t3_cycles", 64'(ncyc), 7);
    settle("t3");

    // 4: both held; four dcache wins, then icache forced through.
    dc_we   = 1'b0;
    dc_addr = 32'h0000_3000;
    ic_addr = 32'h0000_7000;
    dc_req  = 1'b1;
    ic_req  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        do_burst("t4dc", DC, 32'h0000_3000, 1'b0, 16'h0, 0, -1, lat, ncyc);
      end else begin
        do_burst("t4ic", IC, 32'h0000_7000, 1'b0, 16'h0, 0, -1, lat, ncyc);
        dc_req = 1'b0;
        ic_req = 1'b0;
      end
      check("t4_latency", 64'(lat), (k == 0) ? 1 : 2);
      if (k == 3) check("t4_starve_sat", 64'(dut.u_prio.cnt_q), 4);
    end
    check("t4_starve_clr", 64'(dut.u_prio.cnt_q), 0);
    settle("t4");

    // 5: asynchronous reset during beat 2 of an icache refill.
    ic_addr   = 32'h0000_1234;
    ic_req    = 1'b1;
    mem_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      rd_t e;
      @(negedge clk);
      check("t5_beat_cur", 64'(arb_beat_cur), 64'(b));
      if (b < 2) begin
        e.own  = IC;
        e.beat = 2'(b);
        e.data = mdata(32'h0000_1230 + 32'(4 * b));
        exp_q.push_back(e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_mem_req", 64'(mem_req), 0);
    check("t5_rst_busy", 64'(busy), 0);
    check("t5_rst_ic_rvalid", 64'(ic_rvalid), 0);
    check("t5_rst_ic_done", 64'(ic_done), 0);
    ic_req    = 1'b0;
    mem_ready = 1'b0;
    check("t5_queue_empty", 64'(exp_q.size()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("t5_post_busy", 64'(busy), 0);
    check("t5_post_beat", 64'(arb_beat_cur), 0);
    check("t5_post_starve", 64'(dut.u_prio.cnt_q), 0);

    // 6: dcache refill whose request drops after beat 0.
    dc_we   = 1'b0;
    dc_addr = 32'h0000_4000;
    dc_req  = 1'b1;
    do_burst("t6", DC, 32'h0000_4000, 1'b0, 16'h0, 0, 0, lat, ncyc);
    check("t6_cycles", 64'(ncyc), 4);
    settle("t6");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_regrant", 64'({busy, mem_req}), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the core's single main-memory port between icache line refills and dcache line refills/write-backs. It sits below F_top and C_top. It converts each cache miss into a LINE_WORDS-beat burst and returns data or a completion pulse to the owning cache. Dcache has priority because a dcache stall freezes the whole pipeline. A starvation counter guarantees that instruction fetch still makes progress.

Parameters:
LINE_WORDS, 4, words per cache line (power of 2, >=2)
ADDR_W, 32, address width
DATA_W, 32, data word width
STARVE_LIM, 4, consecutive dcache wins over a pending icache request before icache is forced to win

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
ic_req  in  1  icache refill request, held until ic_done
ic_addr  in  ADDR_W  icache miss address
ic_rvalid  out  1  arb_rdata holds an icache word
ic_done  out  1  icache burst complete (1-cycle pulse)
dc_req  in  1  dcache request, held until dc_done
dc_we  in  1  1 = write-back, 0 = refill
dc_addr  in  ADDR_W  dcache line address
dc_wdata  in  DATA_W  write word for index arb_beat_cur (combinational from dcache)
dc_rvalid  out  1  arb_rdata holds a dcache word
dc_done  out  1  dcache burst complete (1-cycle pulse)
arb_rdata  out  DATA_W  registered read word
arb_beat  out  log2(LINE_WORDS)  word index of arb_rdata
arb_beat_cur  out  log2(LINE_WORDS)  current beat index (write data select)
mem_req  out  1  burst active
mem_we  out  1  burst is a write
mem_addr  out  ADDR_W  current word address
mem_wdata  out  DATA_W  write data (= dc_wdata)
mem_rdata  in  DATA_W  read data, valid when mem_ready
mem_ready  in  1  beat accepted/returned this cycle
busy  out  1  FSM not IDLE
owner  out  1  0 = icache, 1 = dcache (valid while busy)

Behaviour:
- States: IDLE, BURST, DONE. The beat counter is log2(LINE_WORDS) bits. The base address is the request address with its low log2(LINE_WORDS)+2 bits cleared.
- IDLE decision at each rising edge:
  - If dc_req=1 and (ic_req=0 or starve_cnt<STARVE_LIM): grant dcache.
  - Else if ic_req=1: grant icache.
  - Else: stay in IDLE.
  - On a grant, latch the base address, owner and we (we=0 for icache); clear the beat counter; go to BURST.
- starve_cnt:
  - Increments on a dcache grant made while ic_req=1 (saturates at STARVE_LIM).
  - Clears on an icache grant, and clears in IDLE when ic_req=0.
- BURST:
  - mem_req=1; mem_addr = base + 4*beat; mem_we = latched we.
  - On each cycle with mem_ready=1, beat increments.
  - On the beat where beat == LINE_WORDS-1 and mem_ready=1, go to DONE.
  - mem_ready=0 holds all state. There is no timeout.
- Read beats: one cycle after a beat with mem_ready=1, arb_rdata=mem_rdata, arb_beat=that beat index, and the owner's rvalid=1.
- DONE (exactly one cycle):
  - The owner's done=1, coinciding with the last rvalid on reads.
  - mem_req=0.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle N; mem_req=1 from N+1. The last accepted beat at cycle M gives done at M+1 and IDLE at M+2. Minimum burst turnaround is LINE_WORDS+2 cycles.
- The requester deasserts req after sampling done. A req still high in the IDLE cycle is treated as a new request.
- A req dropped mid-burst is ignored; the burst completes and done still pulses.
- Address and we changes after the grant are ignored.
- Writes: mem_wdata = dc_wdata combinationally. The dcache indexes its write data with arb_beat_cur.
- Reset (asynchronous, active-low), even mid-burst: state=IDLE, and all outputs, counters and registers go to 0 immediately. Memory must treat the mem_req drop as an abort.
- owner and busy are registered state outputs.

Decomposition:
- Shared package mem_arb_pkg: FSM state encoding (IDLE/BURST/DONE), owner encoding (OWN_IC=0, OWN_DC=1), and the BEAT_W = log2(LINE_WORDS) and line-offset-mask helpers.
- One sub-module, arb_prio_starve: IDLE grant decision plus starve_cnt. The FSM, beat counter and datapath stay in mem_arbiter.

Test Plan:
1. Icache only, ic_addr=0x0000_1234, mem_ready=1 held, requester drops ic_req after ic_done -> mem_req high in cycles 1–4 with mem_addr 0x1230/0x1234/0x1238/0x123C; ic_rvalid in cycles 2–5 with arb_beat 0..3; ic_done in cycle 5; next grant (if any) no earlier than cycle 6.
2. ic_req and dc_req (we=0, addr 0x2000) rise together in IDLE -> dcache burst at 0x2000–0x200C first; after dc_done and one IDLE cycle, icache burst starts; starve_cnt=1 then 0.
3. Dcache write, dc_addr=0x8000_0044, mem_ready pattern 1,0,0,1,1,0,1 -> mem_we=1, mem_addr 0x8000_0040/44/48/4C, each held while not ready; arb_beat_cur steps 0→3; dc_done one cycle after the 7th pattern cycle.
4. dc_req held constantly and ic_req held -> 4 consecutive dcache bursts, then icache wins the 5th grant; starve_cnt returns to 0.
5. reset asserted asynchronously on beat 2 of an icache burst -> mem_req, busy, ic_rvalid and ic_done go 0 without waiting for an edge; after release, IDLE with beat=0 and starve_cnt=0.
6. dc_req dropped after beat 0 of a refill -> all 4 beats issued, dc_rvalid 4 times, dc_done pulses, then IDLE with no re-grant.
